mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 16, meaning cycles in an access state without ramready before abort (range 2..255).
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port iREN  in  1  instruction fetch request, held until iwait is low.
REQ-005 SHALL have port iaddr  in  32  instruction word address.
REQ-006 SHALL have port iwait  out  1  fetch not complete this cycle.
REQ-007 SHALL have port iload  out  32  fetched instruction.
REQ-008 SHALL have ports dREN  in  1 (data read request) and dWEN  in  1 (data write request).
REQ-009 SHALL have ports daddr  in  32 (data address) and dstore  in  32 (write data).
REQ-010 SHALL have ports dwait  out  1 (data access not complete) and dload  out  32 (read data).
REQ-011 SHALL have ports ramREN  out  1, ramWEN  out  1, ramaddr  out  32 and ramstore  out  32, forming the single shared RAM port.
REQ-012 SHALL have ports ramload  in  32 (RAM read data) and ramready  in  1 (one-cycle pulse: access complete).
REQ-013 SHALL have port tmo_err  out  1  sticky flag: a RAM access timed out.

Function
REQ-014 SHALL implement FSM states IDLE, IACC and DACC.
REQ-015 In IDLE, a pending dREN|dWEN SHALL move the FSM to DACC; else a pending iREN SHALL move it to IACC; else the FSM SHALL stay in IDLE.
REQ-016 Exception to REQ-015: if the last completed access was data and iREN is pending, IDLE SHALL go to IACC (alternation, no fetch starvation).
REQ-017 On grant, the FSM SHALL latch the address, dstore and the write flag (dWEN) into registers; ramaddr and ramstore SHALL be driven only from these latched registers.
REQ-018 If dREN and dWEN are both high at grant, the access SHALL be treated as a write.
REQ-019 In IACC, ramREN=1 and ramWEN=0.
REQ-020 In DACC, ramWEN=latched write flag and ramREN=~latched write flag.
REQ-021 In IDLE, ramREN=ramWEN=0.
REQ-022 Completion occurs on a cycle with ramready=1 in IACC or DACC; the next state SHALL be IDLE.
REQ-023 Grant latency from IDLE SHALL be 1 cycle; minimum request-to-release latency SHALL be 2 cycles.
REQ-024 iwait = iREN & ~(state==IACC & ramready), computed combinationally.
REQ-025 dwait = (dREN|dWEN) & ~(state==DACC & ramready), computed combinationally.
REQ-026 iload and dload SHALL equal ramload combinationally; they are valid only in the completion cycle.
REQ-027 If a requester drops its request mid-access, the RAM access SHALL still run to ramready or timeout, with no effect on the other requester.
REQ-028 ramready in IDLE SHALL be ignored.
REQ-029 A timeout counter SHALL clear on entry to IACC/DACC and increment each cycle without ramready.
REQ-030 When the counter reaches TMO_CYCLES-1 without ramready, the FSM SHALL return to IDLE, set tmo_err and leave the corresponding wait high.
REQ-031 The counter SHALL saturate and never wrap.
REQ-032 A completion and a new request in the same cycle SHALL NOT cause a re-grant in that cycle; the FSM passes through IDLE.

Reset
REQ-033 With RST high at a rising edge, the FSM SHALL go to IDLE and clear the counter, tmo_err, the latched registers and the last-access-was-data flag.
REQ-034 After reset, ramREN, ramWEN, ramaddr and ramstore SHALL be 0; iwait/dwait SHALL follow REQ-024/025.
REQ-035 Reset mid-access SHALL abandon the access; a later ramready SHALL be ignored.

Verification
REQ-036 Fetch: iREN=1, iaddr=0x40; ramready on 2nd cycle in IACC with ramload=0x3C010001 -> ramREN=1, ramaddr=0x40, iwait low only in that cycle, iload=0x3C010001.
REQ-037 Contention: iREN=dREN=1 from IDLE -> DACC first, then IACC; dwait drops before iwait.
REQ-038 Write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF until ramready; dwait then low 1 cycle.
REQ-039 Timeout: dREN=1, ramready never asserted -> after 16 cycles in DACC the FSM returns to IDLE and tmo_err=1 stays set until RST.
REQ-040 Reset mid-access: RST in the 2nd cycle of IACC -> next cycle IDLE, ramREN=0; a ramready pulse a cycle later causes no iwait drop.
REQ-041 Starvation: dREN held high continuously with iREN=1 -> the grant sequence alternates D, I, D, I.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared bus between the fetch/data requesters, the arbiter and the single RAM port.
// The arbiter takes the slave side; the requesters and RAM model take the master side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data) onto one RAM port, with
// data priority, fetch/data alternation and a per-access timeout.
module mem_arbiter #(
    parameter int unsigned TMO_CYCLES = 16
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus,
    output logic          tmo_err
);

    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  tmo_cnt;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic        wr_q;
    logic        last_data;
    logic        dreq;
    logic        grant_i;
    logic        grant_d;
    logic        done;
    logic        timeout;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tmo_cnt   <= 8'd0;
            tmo_err   <= 1'b0;
            addr_q    <= 32'd0;
            store_q   <= 32'd0;
            wr_q      <= 1'b0;
            last_data <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_i || grant_d) begin
                tmo_cnt <= 8'd0;
            end else if (state != IDLE && !bus.ramready && tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (grant_i) begin
                addr_q <= bus.iaddr;
                wr_q   <= 1'b0;
            end
            if (grant_d) begin
                addr_q  <= bus.daddr;
                store_q <= bus.dstore;
                wr_q    <= bus.dWEN;
            end
            // Only a real completion decides whose turn is next; an abort does not.
            if (done) begin
                last_data <= (state == DACC);
            end
            if (timeout) begin
                tmo_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        done         = 1'b0;
        timeout      = 1'b0;
        dreq         = bus.dREN | bus.dWEN;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = addr_q;
        bus.ramstore = store_q;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;
        bus.iwait    = bus.iREN;
        bus.dwait    = dreq;

        case (state)
            IDLE: begin
                // Data wins unless it was served last and a fetch is waiting.
                if (bus.iREN && (last_data || !dreq)) begin
                    grant_i   = 1'b1;
                    state_nxt = IACC;
                end else if (dreq) begin
                    grant_d   = 1'b1;
                    state_nxt = DACC;
                end
            end
            IACC, DACC: begin
                if (state == IACC) begin
                    bus.ramREN = 1'b1;
                    bus.iwait  = bus.iREN & ~bus.ramready;
                end else begin
                    bus.ramWEN = wr_q;
                    bus.ramREN = ~wr_q;
                    bus.dwait  = dreq & ~bus.ramready;
                end
                if (bus.ramready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt >= TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the fetch, contention, write, timeout, reset and alternation cases.
module tb_mem_arbiter;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    logic tmo_err;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.TMO_CYCLES(TMO)) dut (
        .CLK     (clk),
        .RST     (rst),
        .bus     (bus),
        .tmo_err (tmo_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the RAM (0 none, 1 fetch, 2 data), how long it has waited, and whose turn it is.
    int          m_own = 0;
    int          m_age = 0;
    bit          m_last_d = 1'b0;
    bit          m_tmo = 1'b0;
    bit          m_wr = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_store = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_own <= 0; m_age <= 0; m_last_d <= 1'b0; m_tmo <= 1'b0;
            m_wr <= 1'b0; m_addr <= 32'd0; m_store <= 32'd0; m_valid <= 1'b1;
        end else if (m_own == 0) begin
            if (bus.iREN && (m_last_d || !(bus.dREN || bus.dWEN))) begin
                m_own <= 1; m_age <= 0; m_addr <= bus.iaddr; m_wr <= 1'b0;
            end else if (bus.dREN || bus.dWEN) begin
                m_own <= 2; m_age <= 0; m_addr <= bus.daddr; m_store <= bus.dstore; m_wr <= bus.dWEN;
            end
        end else if (bus.ramready) begin
            m_own <= 0;
            m_last_d <= (m_own == 2);
        end else if (m_age == TMO - 1) begin
            m_own <= 0;
            m_tmo <= 1'b1;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("m_ramREN", 32'(bus.ramREN), 32'((m_own == 1) || (m_own == 2 && !m_wr)));
            cmp("m_ramWEN", 32'(bus.ramWEN), 32'(m_own == 2 && m_wr));
            cmp("m_ramaddr", bus.ramaddr, m_addr);
            cmp("m_ramstore", bus.ramstore, m_store);
            cmp("m_iwait", 32'(bus.iwait), 32'(bus.iREN && !(m_own == 1 && bus.ramready)));
            cmp("m_dwait", 32'(bus.dwait), 32'((bus.dREN || bus.dWEN) && !(m_own == 2 && bus.ramready)));
            cmp("m_iload", bus.iload, bus.ramload);
            cmp("m_dload", bus.dload, bus.ramload);
            cmp("m_tmo_err", 32'(tmo_err), 32'(m_tmo));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Bounded wait for the next RAM access to appear; returns 1 on success.
    task automatic wait_access(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (bus.ramREN || bus.ramWEN) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    string grants;
    string exp_seq;
    bit    ok;

    initial begin
        rst = 1'b1;
        bus.iREN = 1'b0; bus.iaddr = 32'd0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = 32'd0; bus.dstore = 32'd0; bus.ramload = 32'd0; bus.ramready = 1'b0;
        step(); step();
        rst = 1'b0;
        settle();
        cmp("rst_ramREN", 32'(bus.ramREN), 32'd0);
        cmp("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        cmp("rst_ramaddr", bus.ramaddr, 32'd0);
        cmp("rst_ramstore", bus.ramstore, 32'd0);
        cmp("rst_tmo_err", 32'(tmo_err), 32'd0);

        // Fetch from 0x40, RAM answers on the second IACC cycle.
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        settle();
        cmp("fetch_idle_iwait", 32'(bus.iwait), 32'd1);
        step();
        cmp("fetch_c1_ramREN", 32'(bus.ramREN), 32'd1);
        cmp("fetch_c1_ramaddr", bus.ramaddr, 32'h40);
        cmp("fetch_c1_iwait", 32'(bus.iwait), 32'd1);
        step();
        bus.ramready = 1'b1; bus.ramload = 32'h3C010001;
        settle();
        cmp("fetch_done_iwait", 32'(bus.iwait), 32'd0);
        cmp("fetch_done_iload", bus.iload, 32'h3C010001);
        step();
        bus.ramready = 1'b0; bus.iREN = 1'b0;
        settle();
        cmp("fetch_after_ramREN", 32'(bus.ramREN), 32'd0);

        // Contention: data goes first, then the fetch.
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h104;
        step();
        cmp("cont_first_addr", bus.ramaddr, 32'h104);
        cmp("cont_first_ramREN", 32'(bus.ramREN), 32'd1);
        bus.ramready = 1'b1; bus.ramload = 32'h11112222;
        settle();
        cmp("cont_dwait", 32'(bus.dwait), 32'd0);
        cmp("cont_iwait_held", 32'(bus.iwait), 32'd1);
        cmp("cont_dload", bus.dload, 32'h11112222);
        step();
        bus.ramready = 1'b0; bus.dREN = 1'b0;
        settle();
        cmp("cont_pass_idle", 32'(bus.ramREN), 32'd0);
        step();
        cmp("cont_second_addr", bus.ramaddr, 32'h44);
        bus.ramready = 1'b1;
        settle();
        cmp("cont_iwait", 32'(bus.iwait), 32'd0);
        step();
        bus.ramready = 1'b0; bus.iREN = 1'b0;

        // Write with dREN and dWEN both high: treated as a write.
        step();
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        step();
        for (int k = 0; k < 2; k++) begin
            cmp("wr_ramWEN", 32'(bus.ramWEN), 32'd1);
            cmp("wr_ramREN", 32'(bus.ramREN), 32'd0);
            cmp("wr_ramstore", bus.ramstore, 32'hDEADBEEF);
            cmp("wr_ramaddr", bus.ramaddr, 32'h100);
            cmp("wr_dwait", 32'(bus.dwait), 32'd1);
            step();
        end
        bus.ramready = 1'b1;
        settle();
        cmp("wr_done_dwait", 32'(bus.dwait), 32'd0);
        step();
        bus.ramready = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;

        // Fetch dropped mid-access still runs to ramready.
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h48;
        step();
        bus.iREN = 1'b0;
        step();
        cmp("drop_still_ramREN", 32'(bus.ramREN), 32'd1);
        bus.ramready = 1'b1;
        step();
        bus.ramready = 1'b0;
        settle();
        cmp("drop_released", 32'(bus.ramREN), 32'd0);

        // Timeout: data read that the RAM never answers.
        step();
        bus.dREN = 1'b1; bus.daddr = 32'h180;
        step();
        for (int k = 0; k < TMO; k++) begin
            if (!bus.ramREN || tmo_err) begin
                cmp("tmo_in_dacc", {30'd0, bus.ramREN, tmo_err}, 32'd2);
            end
            step();
        end
        cmp("tmo_idle_ramREN", 32'(bus.ramREN), 32'd0);
        cmp("tmo_err_set", 32'(tmo_err), 32'd1);
        cmp("tmo_dwait_high", 32'(bus.dwait), 32'd1);
        bus.dREN = 1'b0;
        step(); step(); step();
        cmp("tmo_err_sticky", 32'(tmo_err), 32'd1);

        // Reset during the second IACC cycle; a later ramready is ignored.
        bus.iREN = 1'b1; bus.iaddr = 32'h4C;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; bus.ramready = 1'b1;
        settle();
        cmp("rst_mid_ramREN", 32'(bus.ramREN), 32'd0);
        cmp("rst_mid_iwait", 32'(bus.iwait), 32'd1);
        cmp("rst_mid_tmo_clr", 32'(tmo_err), 32'd0);
        step();
        bus.ramready = 1'b0; bus.iREN = 1'b0;
        step();
        bus.ramready = 1'b1;
        step();
        bus.ramready = 1'b0;

        // Alternation with both requesters held high.
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h200;
        grants = "";
        for (int g = 0; g < 4; g++) begin
            step();
            wait_access(ok);
            if (!ok) begin
                cmp("alt_grant_timeout", 32'd0, 32'd1);
                break;
            end
            grants = {grants, (bus.ramaddr == 32'h200) ? "D" : "I"};
            bus.ramready = 1'b1;
            step();
            bus.ramready = 1'b0;
        end
        exp_seq = "DIDI";
        total++;
        if (grants != exp_seq) begin
            bad++;
            $display("FAIL alt_sequence: got %s want %s", grants, exp_seq);
        end
        bus.iREN = 1'b0; bus.dREN = 1'b0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
